// File: rtl/vga_fb_arbiter_pkg.sv
// Shared framebuffer geometry, pixel-period phase encoding and address helpers
// for the VGA framebuffer arbiter.
package vga_fb_arbiter_pkg;

  localparam int FB_WIDTH  = 120;
  localparam int FB_HEIGHT = 160;
  localparam int ADDR_W    = 15;
  localparam int COLOR_W   = 12;
  localparam int POS_W     = 12;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    PH_DISP = 2'd0,
    PH_1    = 2'd1,
    PH_2    = 2'd2,
    PH_3    = 2'd3
  } phase_e;

  localparam logic [ADDR_W-1:0] FB_W_VEC = ADDR_W'(FB_WIDTH);

  // row*FB_WIDTH + col as a shift-add over the set bits of the constant width
  function automatic logic [ADDR_W-1:0] fb_lin_addr(input logic [POS_W-1:0] row,
                                                     input logic [POS_W-1:0] col);
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] acc;
    r   = ADDR_W'(row);
    acc = ADDR_W'(col);
    for (int i = 0; i < ADDR_W; i++) begin
      if (FB_W_VEC[i]) acc = acc + (r << i);
    end
    return acc;
  endfunction

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(FB_DEPTH);
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_fb_bram.sv
// Single-port synchronous-read framebuffer RAM; read-first, no reset so it
// maps onto block RAM.
module fb_bram
  import vga_fb_arbiter_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = ADDR_W,
  parameter int DW    = COLOR_W
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer owner: time-shares one BRAM port between VGA scanout (phase-0
// slot of each 4-clk pixel period) and CPU bus accesses (all other slots).
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               pxclk,
  input  logic               inframe,
  input  logic [POS_W-1:0]   hpos,
  input  logic [POS_W-1:0]   vpos,
  output logic [COLOR_W-1:0] pix_rgb,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [COLOR_W-1:0] cpu_wdata,
  output logic               cpu_ack,
  output logic               cpu_rvalid,
  output logic [COLOR_W-1:0] cpu_rdata
);

  phase_e             phase_q, phase_d;
  logic               pxclk_q;
  logic               disp_vld_q, disp_vld_d;
  logic [COLOR_W-1:0] pix_q, pix_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rd_oob_q, rd_oob_d;
  logic [COLOR_W-1:0] rdata_q, rdata_d;

  logic               rise;
  logic               disp_ok;
  logic               disp_slot;
  logic               cpu_go;
  logic               cpu_in_rng;
  logic [ADDR_W-1:0]  disp_addr;
  logic [COLOR_W-1:0] rdata_now;

  logic               ram_en;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [COLOR_W-1:0] ram_dout;

  assign rise       = pxclk & ~pxclk_q;
  assign disp_ok    = inframe && (hpos < POS_W'(FB_WIDTH)) && (vpos < POS_W'(FB_HEIGHT));
  assign disp_slot  = (phase_q == PH_DISP) && disp_ok;
  assign disp_addr  = fb_lin_addr(vpos, hpos);
  assign cpu_in_rng = addr_in_range(cpu_addr);
  assign cpu_go     = ~disp_slot & cpu_req & ~rst;

  // Out-of-range CPU accesses are acked but never touch the array
  assign ram_en   = disp_slot | (cpu_go & cpu_in_rng);
  assign ram_we   = cpu_go & cpu_we & cpu_in_rng;
  assign ram_addr = disp_slot ? disp_addr : cpu_addr;

  fb_bram u_fb_bram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (cpu_wdata),
    .dout (ram_dout)
  );

  assign rdata_now = rd_oob_q ? '0 : ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_DISP;
      pxclk_q    <= 1'b0;
      disp_vld_q <= 1'b0;
      pix_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_oob_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      pxclk_q    <= pxclk;
      disp_vld_q <= disp_vld_d;
      pix_q      <= pix_d;
      rd_pend_q  <= rd_pend_d;
      rd_oob_q   <= rd_oob_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    phase_d    = phase_e'(phase_q + 2'd1);
    disp_vld_d = disp_vld_q;
    pix_d      = pix_q;
    rd_pend_d  = cpu_go & ~cpu_we;
    rd_oob_d   = ~cpu_in_rng;
    rdata_d    = rdata_q;
    if (rise) phase_d = PH_DISP;
    if (phase_q == PH_DISP) disp_vld_d = disp_ok;
    // Pixel register only updates once per period, one clk after the display read
    if (phase_q == PH_1) pix_d = disp_vld_q ? ram_dout : '0;
    if (rd_pend_q) rdata_d = rdata_now;
  end

  assign pix_rgb    = pix_q;
  assign cpu_ack    = cpu_go;
  // Gating with rst drops a read whose data would arrive during reset
  assign cpu_rvalid = rd_pend_q & ~rst;
  assign cpu_rdata  = rst ? '0 : (rd_pend_q ? rdata_now : rdata_q);

endmodule
